// File: rtl/sdram_slave_responder.sv
// Avalon-MM 16-bit slave memory with programmable wait states, standing in for SDRAM.
// Counts completed accesses and keeps sticky error flags for bring-up.
module sdram_slave_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          READ_WAIT  = 2,
    parameter int          WRITE_WAIT = 1,
    parameter logic [15:0] OOB_DATA   = 16'hDEAD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    input  logic        cnt_clr,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [1:0]  err,
    output logic [1:0]  dbg_state
);

    // Handshake: the master holds read/write until it sees waitrequest low;
    // waitrequest drops for exactly one cycle (ACK) per completed access.
    localparam int          WORDS     = 2 ** DEPTH_LOG2;
    localparam logic [31:0] MEM_BYTES = 32'(2 * WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt;
    logic [31:0]           addr_q;
    logic [15:0]           wdata_q;
    logic                  op_wr;
    logic [15:0]           mem [0:WORDS-1];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oob;
    logic                  rd_done, wr_done, oob_evt, both_evt;

    assign idx = addr_q[DEPTH_LOG2:1];
    assign oob = (addr_q >= MEM_BYTES);

    always_comb begin
        state_nxt       = state;
        avs_waitrequest = 1'b1;
        rd_done         = 1'b0;
        wr_done         = 1'b0;
        oob_evt         = 1'b0;
        both_evt        = 1'b0;
        case (state)
            IDLE: begin
                both_evt = avs_read && avs_write;
                if (avs_write)     state_nxt = WR_WAIT;
                else if (avs_read) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (!avs_read)           state_nxt = IDLE;
                else if (wait_cnt == '0) state_nxt = ACK;
            end
            WR_WAIT: begin
                if (!avs_write)          state_nxt = IDLE;
                else if (wait_cnt == '0) state_nxt = ACK;
            end
            ACK: begin
                avs_waitrequest = 1'b0;
                rd_done         = !op_wr;
                wr_done         = op_wr;
                oob_evt         = oob;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_wr        <= 1'b0;
            avs_readdata <= '0;
            rd_count     <= '0;
            wr_count     <= '0;
            err          <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (avs_write) begin
                        addr_q   <= avs_address;
                        wdata_q  <= avs_writedata;
                        op_wr    <= 1'b1;
                        wait_cnt <= 4'(WRITE_WAIT);
                    end else if (avs_read) begin
                        addr_q   <= avs_address;
                        op_wr    <= 1'b0;
                        wait_cnt <= 4'(READ_WAIT);
                    end
                end
                RD_WAIT: begin
                    if (avs_read && wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
                    if (state_nxt == ACK) avs_readdata <= oob ? OOB_DATA : mem[idx];
                end
                WR_WAIT: begin
                    if (avs_write && wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
                end
                default: ;
            endcase
            // A clear on the same edge as an event swallows that event.
            if (cnt_clr) begin
                rd_count <= '0;
                wr_count <= '0;
                err      <= '0;
            end else begin
                if (rd_done) rd_count <= rd_count + 32'd1;
                if (wr_done) wr_count <= wr_count + 32'd1;
                err <= err | {both_evt, oob_evt};
            end
        end
    end

    // Array is deliberately not reset; a reset during ACK still blocks the commit.
    always_ff @(posedge clk) begin
        if (reset_n && state == ACK && op_wr && !oob) mem[idx] <= wdata_q;
    end

endmodule
